// File: rtl/ber_window_monitor_pkg.sv
// Shared types and default widths for the BER window monitor.
package ber_pkg;

    localparam int DEF_DATA_W   = 64;
    localparam int DEF_ERRCNT_W = 7;
    localparam int DEF_WIN_W    = 32;
    localparam int DEF_SUM_W    = 32;

    localparam logic [DEF_SUM_W-1:0] SUM_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LOCK,
        MEASURE,
        REPORT
    } berState_t;

endpackage

// File: rtl/ber_window_monitor_sat_accum.sv
// Saturating accumulator: sum sticks at all-ones instead of wrapping.
module sat_accum #(
    parameter int W     = 32,
    parameter int ADD_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [ADD_W-1:0] addend,
    output logic [W-1:0]     sum
);

    // One extra bit is enough to detect overflow since addend is narrower than sum.
    logic [W:0] wide;
    assign wide = {1'b0, sum} + {{(W + 1 - ADD_W){1'b0}}, addend};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (en) begin
            sum <= wide[W] ? {W{1'b1}} : wide[W-1:0];
        end
    end

endmodule

// File: rtl/ber_window_monitor.sv
// Accumulates per-word bit-error statistics over a programmable window of
// aligned words and presents one record per window on a valid/ready port.
module ber_window_monitor
    import ber_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ERRCNT_W = DEF_ERRCNT_W,
    parameter int WIN_W    = DEF_WIN_W,
    parameter int SUM_W    = DEF_SUM_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                aligned,
    input  logic [ERRCNT_W-1:0] err_count,
    input  logic [DATA_W-1:0]   err_bits,
    input  logic [WIN_W-1:0]    win_len,
    input  logic                start,
    input  logic                stop,
    input  logic                cont,
    output logic                busy,
    output logic                stat_valid,
    input  logic                stat_ready,
    output logic [WIN_W-1:0]    stat_words,
    output logic [SUM_W-1:0]    stat_errs,
    output logic [WIN_W-1:0]    stat_err_words,
    output logic [ERRCNT_W-1:0] stat_max_err,
    output logic [DATA_W-1:0]   stat_lane_mask,
    output logic                stat_unlock,
    output logic                overflow
);

    localparam logic [WIN_W-1:0] ONE = {{(WIN_W - 1){1'b0}}, 1'b1};

    berState_t state, stateNext;

    logic [WIN_W-1:0]    effLen;
    logic [WIN_W-1:0]    words;
    logic [WIN_W-1:0]    wordsInc;
    logic [WIN_W-1:0]    errWords;
    logic [ERRCNT_W-1:0] maxErr;
    logic [DATA_W-1:0]   laneMask;
    logic [SUM_W-1:0]    errSum;
    logic                unlockFlag;

    logic countWord;
    logic clrAcc;
    logic latchLen;
    logic setUnlock;

    assign wordsInc = words + ONE;
    assign busy     = (state == WAIT_LOCK) || (state == MEASURE);

    always_comb begin
        stateNext = state;
        countWord = 1'b0;
        clrAcc    = 1'b0;
        latchLen  = 1'b0;
        setUnlock = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    latchLen  = 1'b1;
                    stateNext = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                clrAcc = 1'b1;
                if (stop) begin
                    stateNext = IDLE;
                end else if (aligned) begin
                    stateNext = MEASURE;
                end
            end
            MEASURE: begin
                // The closing word is counted in the same cycle it is seen.
                if (stop) begin
                    stateNext = REPORT;
                end else if (!aligned) begin
                    setUnlock = 1'b1;
                    stateNext = REPORT;
                end else begin
                    countWord = 1'b1;
                    if (wordsInc == effLen) begin
                        stateNext = REPORT;
                    end
                end
            end
            REPORT: begin
                if (cont) begin
                    latchLen  = 1'b1;
                    stateNext = WAIT_LOCK;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            effLen <= '0;
        end else begin
            state <= stateNext;
            if (latchLen) begin
                effLen <= (win_len == '0) ? ONE : win_len;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            words      <= '0;
            errWords   <= '0;
            maxErr     <= '0;
            laneMask   <= '0;
            unlockFlag <= 1'b0;
        end else if (clrAcc) begin
            words      <= '0;
            errWords   <= '0;
            maxErr     <= '0;
            laneMask   <= '0;
            unlockFlag <= 1'b0;
        end else begin
            if (countWord) begin
                words    <= wordsInc;
                laneMask <= laneMask | err_bits;
                if (err_count != '0) begin
                    errWords <= errWords + ONE;
                end
                if (err_count > maxErr) begin
                    maxErr <= err_count;
                end
            end
            if (setUnlock) begin
                unlockFlag <= 1'b1;
            end
        end
    end

    sat_accum #(
        .W     (SUM_W),
        .ADD_W (ERRCNT_W)
    ) errAccum (
        .clk    (clk),
        .reset  (reset),
        .clr    (clrAcc),
        .en     (countWord),
        .addend (err_count),
        .sum    (errSum)
    );

    // A new record may replace one being accepted this same cycle; otherwise it is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_valid     <= 1'b0;
            stat_words     <= '0;
            stat_errs      <= '0;
            stat_err_words <= '0;
            stat_max_err   <= '0;
            stat_lane_mask <= '0;
            stat_unlock    <= 1'b0;
            overflow       <= 1'b0;
        end else if (state == REPORT) begin
            if (!stat_valid || stat_ready) begin
                stat_valid     <= 1'b1;
                stat_words     <= words;
                stat_errs      <= errSum;
                stat_err_words <= errWords;
                stat_max_err   <= maxErr;
                stat_lane_mask <= laneMask;
                stat_unlock    <= unlockFlag;
            end else begin
                overflow <= 1'b1;
            end
        end else if (stat_valid && stat_ready) begin
            stat_valid <= 1'b0;
        end
    end

endmodule
